// File: rtl/stack_pkg.sv
// Shared definitions for the stack controller: op codes, FSM encoding, port IDs.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package stack_pkg;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  localparam logic PORT_A  = 1'b0;
  localparam logic PORT_B  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/stack_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; remembers the last granted port.
// Latency: grant is combinational; last_grant updates on the granting edge.
// Backpressure: grants only while en is high; losers keep their request asserted.
module rr_arb2 (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_vld,
  output logic gnt_id
);
  import stack_pkg::*;

  logic last_grant_q;
  logic last_grant_d;

  // Pick the single requester, or on a tie the one not served last.
  always_comb begin
    gnt_vld = en & (req_a | req_b);
    if (req_a && req_b) begin
      gnt_id = (last_grant_q == PORT_A) ? PORT_B : PORT_A;
    end else if (req_b) begin
      gnt_id = PORT_B;
    end else begin
      gnt_id = PORT_A;
    end
  end

  // Remember the winner of every grant, accepted or rejected downstream.
  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt_vld) begin
      last_grant_d = gnt_id;
    end
  end

  // Reset to B so that A wins the first tie.
  always_ff @(posedge clk) begin
    if (clr) begin
      last_grant_q <= PORT_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/stack_ctrl.sv
// Two-requester front end for a hardware stack: arbitrates, checks occupancy, drives the stack.
// Latency: grant edge to ack is 2 cycles for a legal op, 1 cycle for a rejected one.
// Backpressure: requesters hold req/op/wdata until ack; one operation per 3 cycles at best.
module stack_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req_a,
  input  logic             req_b,
  input  logic             op_a,
  input  logic             op_b,
  input  logic [WIDTH-1:0] wdata_a,
  input  logic [WIDTH-1:0] wdata_b,
  output logic             ack_a,
  output logic             ack_b,
  output logic             err_a,
  output logic             err_b,
  output logic [WIDTH-1:0] rdata,
  output logic             stk_en,
  output logic             stk_c,
  output logic [WIDTH-1:0] stk_push,
  input  logic [WIDTH-1:0] stk_peek,
  output logic             stk_clr_n,
  output logic             full,
  output logic             empty
);
  import stack_pkg::*;

  localparam int unsigned   CAP_I = 1 << DEPTH;
  localparam logic [DEPTH:0] CAP  = CAP_I[DEPTH:0];
  localparam logic [DEPTH:0] ONE  = {{DEPTH{1'b0}}, 1'b1};
  localparam logic [DEPTH:0] ZERO = '0;

  state_e           state_q, state_d;
  logic [DEPTH:0]   count_q, count_d;
  logic             port_q, port_d;
  logic             op_q, op_d;
  logic             rej_q, rej_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             stk_en_q, stk_en_d;
  logic             stk_c_q, stk_c_d;
  logic [WIDTH-1:0] stk_push_q, stk_push_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  logic             gnt_vld;
  logic             gnt_id;
  logic             sel_op;
  logic [WIDTH-1:0] sel_wdata;
  logic             legal;

  rr_arb2 u_arb (
    .clk     (clk),
    .clr     (clr),
    .en      (state_q == IDLE),
    .req_a   (req_a),
    .req_b   (req_b),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  // Select the winner's request and decide whether the stack can take it.
  always_comb begin
    sel_op    = (gnt_id == PORT_B) ? op_b : op_a;
    sel_wdata = (gnt_id == PORT_B) ? wdata_b : wdata_a;
    if (sel_op == OP_PUSH) begin
      legal = (count_q < CAP);
    end else begin
      legal = (count_q != ZERO);
    end
  end

  // FSM state register; clear aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: rejected grants skip the stack access cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d = legal ? ISSUE : RESP;
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: the granted port sees ack (and err if rejected) for the RESP cycle.
  always_comb begin
    ack_a = (state_q == RESP) && (port_q == PORT_A);
    ack_b = (state_q == RESP) && (port_q == PORT_B);
    err_a = ack_a && rej_q;
    err_b = ack_b && rej_q;
  end

  // Datapath next state: latch the request at grant, commit the count after the access.
  always_comb begin
    port_d     = port_q;
    op_d       = op_q;
    rej_d      = rej_q;
    rdata_d    = rdata_q;
    count_d    = count_q;
    stk_en_d   = 1'b0;
    stk_c_d    = 1'b0;
    stk_push_d = '0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          port_d  = gnt_id;
          op_d    = sel_op;
          rej_d   = ~legal;
          rdata_d = (legal && (sel_op == OP_POP)) ? stk_peek : '0;
          if (legal) begin
            stk_en_d   = 1'b1;
            stk_c_d    = sel_op;
            stk_push_d = (sel_op == OP_PUSH) ? sel_wdata : '0;
          end
        end
      end
      ISSUE: begin
        count_d = (op_q == OP_PUSH) ? (count_q + ONE) : (count_q - ONE);
      end
      RESP: begin
        rdata_d = '0;
      end
      default: ;
    endcase
    full_d  = (count_d == CAP);
    empty_d = (count_d == ZERO);
  end

  // Datapath registers, with status flags tracking the committed count.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_q    <= '0;
      port_q     <= PORT_A;
      op_q       <= OP_POP;
      rej_q      <= 1'b0;
      rdata_q    <= '0;
      stk_en_q   <= 1'b0;
      stk_c_q    <= 1'b0;
      stk_push_q <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      count_q    <= count_d;
      port_q     <= port_d;
      op_q       <= op_d;
      rej_q      <= rej_d;
      rdata_q    <= rdata_d;
      stk_en_q   <= stk_en_d;
      stk_c_q    <= stk_c_d;
      stk_push_q <= stk_push_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
    end
  end

  assign rdata     = rdata_q;
  assign stk_en    = stk_en_q;
  assign stk_c     = stk_c_q;
  assign stk_push  = stk_push_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign stk_clr_n = ~clr;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a small behavioural stack attached.
// Latency: n/a.
// Backpressure: requesters hold until ack, as the design expects.
module tb_stack_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       req_a, req_b, op_a, op_b;
  logic [7:0] wdata_a, wdata_b;
  logic       ack_a, ack_b, err_a, err_b;
  logic [7:0] rdata;
  logic       stk_en, stk_c;
  logic [7:0] stk_push;
  logic [7:0] stk_peek;
  logic       stk_clr_n, full, empty;

  int n_chk  = 0;
  int n_fail = 0;

  stack_ctrl #(.WIDTH(8), .DEPTH(1)) dut (
    .clk(clk), .clr(clr),
    .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .ack_a(ack_a), .ack_b(ack_b), .err_a(err_a), .err_b(err_b),
    .rdata(rdata), .stk_en(stk_en), .stk_c(stk_c), .stk_push(stk_push),
    .stk_peek(stk_peek), .stk_clr_n(stk_clr_n), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Behavioural stack: 4 slots, more than the controller may ever use.
  logic [7:0] mem [4];
  int         sp = 0;
  always @(posedge clk) begin
    if (!stk_clr_n) begin
      sp <= 0;
    end else if (stk_en) begin
      if (stk_c) begin
        mem[sp[1:0]] <= stk_push;
        sp <= sp + 1;
      end else if (sp > 0) begin
        sp <= sp - 1;
      end
    end
  end
  always_comb stk_peek = (sp > 0) ? mem[sp[1:0] - 2'd1] : 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stack-side monitor plus the standing protocol properties.
  int         en_cnt = 0;
  logic       last_c;
  logic [7:0] last_push;
  logic       prev_en = 1'b0;
  always @(negedge clk) begin
    if (prev_en && stk_en) chk("en_twice", 32'(stk_en), 32'd0);
    if (err_a) chk("err_a_needs_ack", 32'(ack_a), 32'd1);
    if (err_b) chk("err_b_needs_ack", 32'(ack_b), 32'd1);
    if (stk_en) begin
      en_cnt++;
      last_c    = stk_c;
      last_push = stk_push;
    end
    prev_en = stk_en;
  end

  typedef struct {
    bit         port_b;
    bit         push;
    logic [7:0] d;
    bit         err;
    logic [7:0] rd;
    int         lat;
    bit         full;
    bit         empty;
  } vec_t;

  // Entered at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_op(input string tag, input vec_t v);
    int lat;
    bit got;
    int en0;
    en0 = en_cnt;
    if (v.port_b) begin
      req_b = 1'b1; op_b = v.push; wdata_b = v.d;
    end else begin
      req_a = 1'b1; op_a = v.push; wdata_a = v.d;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      got = v.port_b ? ack_b : ack_a;
    end
    chk({tag, "_ack"},   32'(got), 32'd1);
    chk({tag, "_lat"},   32'(lat), 32'(v.lat));
    chk({tag, "_err"},   32'(v.port_b ? err_b : err_a), 32'(v.err));
    chk({tag, "_other"}, 32'(v.port_b ? ack_a : ack_b), 32'd0);
    chk({tag, "_rdata"}, 32'(rdata), 32'(v.rd));
    chk({tag, "_full"},  32'(full),  32'(v.full));
    chk({tag, "_empty"}, 32'(empty), 32'(v.empty));
    req_a = 1'b0;
    req_b = 1'b0;
    @(negedge clk);
    chk({tag, "_stk_en_cnt"}, 32'(en_cnt - en0), v.err ? 32'd0 : 32'd1);
    if (!v.err) begin
      chk({tag, "_stk_c"}, 32'(last_c), 32'(v.push));
      if (v.push) chk({tag, "_stk_push"}, 32'(last_push), 32'(v.d));
    end
  endtask

  vec_t vecs [6];
  bit   exp_p [3];
  bit   exp_e [3];
  bit   got_p [3];
  bit   got_e [3];

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cyc;
    int acks;

    clr = 1'b1;
    req_a = 1'b0; req_b = 1'b0; op_a = 1'b0; op_b = 1'b0;
    wdata_a = 8'h00; wdata_b = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stk_en",    32'(stk_en),    32'd0);
    chk("rst_stk_c",     32'(stk_c),     32'd0);
    chk("rst_stk_push",  32'(stk_push),  32'd0);
    chk("rst_ack",       32'({ack_a, ack_b, err_a, err_b}), 32'd0);
    chk("rst_rdata",     32'(rdata),     32'd0);
    chk("rst_full",      32'(full),      32'd0);
    chk("rst_empty",     32'(empty),     32'd1);
    chk("rst_stk_clr_n", 32'(stk_clr_n), 32'd0);
    clr = 1'b0;
    @(negedge clk);
    chk("run_stk_clr_n", 32'(stk_clr_n), 32'd1);

    // Fill to capacity, overflow, drain, then underflow from B.
    vecs[0] = '{0, 1, 8'h11, 0, 8'h00, 2, 0, 0};
    vecs[1] = '{0, 1, 8'h22, 0, 8'h00, 2, 1, 0};
    vecs[2] = '{0, 1, 8'h33, 1, 8'h00, 1, 1, 0};
    vecs[3] = '{0, 0, 8'h00, 0, 8'h22, 2, 0, 0};
    vecs[4] = '{0, 0, 8'h00, 0, 8'h11, 2, 0, 1};
    vecs[5] = '{1, 0, 8'h00, 1, 8'h00, 1, 0, 1};
    for (int i = 0; i < 6; i++) do_op($sformatf("v%0d", i), vecs[i]);

    // Both requesters push continuously: A, B, then A is rejected on full.
    exp_p[0] = 1'b0; exp_p[1] = 1'b1; exp_p[2] = 1'b0;
    exp_e[0] = 1'b0; exp_e[1] = 1'b0; exp_e[2] = 1'b1;
    req_a = 1'b1; req_b = 1'b1; op_a = 1'b1; op_b = 1'b1;
    wdata_a = 8'hAA; wdata_b = 8'hBB;
    n = 0;
    cyc = 0;
    while (n < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ack_a || ack_b) begin
        got_p[n] = ack_b;
        got_e[n] = err_a | err_b;
        n++;
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    chk("rr_acks", 32'(n), 32'd3);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("rr%0d_port", i), 32'(got_p[i]), 32'(exp_p[i]));
      chk($sformatf("rr%0d_err", i),  32'(got_e[i]), 32'(exp_e[i]));
    end
    @(negedge clk);
    chk("rr_full", 32'(full), 32'd1);

    // Clear from full, then clear again in the middle of a push.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("clr_empty", 32'(empty), 32'd1);
    chk("clr_full",  32'(full),  32'd0);
    req_a = 1'b1; op_a = 1'b1; wdata_a = 8'h44;
    @(negedge clk);
    chk("abort_issue_en", 32'(stk_en), 32'd1);
    clr = 1'b1;
    #1;
    chk("abort_clr_n", 32'(stk_clr_n), 32'd0);
    @(negedge clk);
    chk("abort_ack",   32'(ack_a), 32'd0);
    chk("abort_empty", 32'(empty), 32'd1);
    chk("abort_en",    32'(stk_en), 32'd0);
    clr = 1'b0;
    req_a = 1'b0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack_a || ack_b) acks++;
    end
    chk("abort_no_ack", 32'(acks), 32'd0);
    vecs[0] = '{0, 0, 8'h00, 1, 8'h00, 1, 0, 1};
    do_op("abort_pop", vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
